// File: rtl/hash_table_multi_match.sv
// rtl/hash_table_multi_match.sv - per-partition multi-match hash table for the partitioned hash join
//
// Clears its rows, absorbs build tuples into a fixed number of slots per row, then
// probes with ready/valid backpressure. It emits one beat per matching build tuple,
// or one unmatched beat per probe tuple.
//
// Ports:
//   clk, resetn                       clock, synchronous active-low reset
//   in_valid_BUILD / in_ready_BUILD   build handshake
//   in_data_BUILD, in_hash_BUILD      build tuple and its hash (row = hash[ROW_BITS-1:0])
//   in_last_BUILD                     final build tuple of the partition
//   in_valid_PROBE / in_ready_PROBE   probe handshake
//   in_data_PROBE, in_hash_PROBE      probe tuple and its hash
//   in_last_PROBE                     final probe tuple of the partition
//   in_serialnum                      probe tag, echoed on every beat of that tuple
//   out_valid / out_ready             result handshake
//   out_data                          {build_tuple, probe_tuple}; build half zero when unmatched
//   out_serialnum, out_was_joined     tag of the probe tuple, match flag
//   out_last                          last beat of the last probe tuple
//   overflow_count                    build tuples dropped on full rows (saturating)
//   phase                             0 Init, 1 Build, 2 Probe, 3 Drain
module hash_table_multi_match #(
  parameter int TUPLE_BITS = 64,
  parameter int KEY_BITS   = 32,
  parameter int ROW_BITS   = 3,
  parameter int SLOTS      = 4
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    in_valid_BUILD,
  output logic                    in_ready_BUILD,
  input  logic [TUPLE_BITS-1:0]   in_data_BUILD,
  input  logic [31:0]             in_hash_BUILD,
  input  logic                    in_last_BUILD,
  input  logic                    in_valid_PROBE,
  output logic                    in_ready_PROBE,
  input  logic [TUPLE_BITS-1:0]   in_data_PROBE,
  input  logic [31:0]             in_hash_PROBE,
  input  logic                    in_last_PROBE,
  input  logic [63:0]             in_serialnum,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [2*TUPLE_BITS-1:0] out_data,
  output logic [63:0]             out_serialnum,
  output logic                    out_was_joined,
  output logic                    out_last,
  output logic [31:0]             overflow_count,
  output logic [1:0]              phase
);

  localparam int NUM_ROWS = 2 ** ROW_BITS;
  localparam int ROW_W    = 8 + SLOTS * TUPLE_BITS;

  localparam logic [1:0] PH_INIT  = 2'd0;
  localparam logic [1:0] PH_BUILD = 2'd1;
  localparam logic [1:0] PH_PROBE = 2'd2;
  localparam logic [1:0] PH_DRAIN = 2'd3;

  localparam logic [7:0] SLOTS_C = 8'(SLOTS);

  // Row storage: [7:0] = fill count, slot i at [8 + i*TUPLE_BITS +: TUPLE_BITS].
  logic [ROW_W-1:0] mem_q [NUM_ROWS];

  logic [1:0]            phase_q, phase_d;
  logic [ROW_BITS-1:0]   init_addr_q, init_addr_d;
  logic [31:0]           ovf_q, ovf_d;

  // Stage registers shared by the build and probe pipelines (the phases never overlap):
  // the row word read on acceptance, the accepted tuple and its last flag.
  logic [ROW_W-1:0]      rd_word_q, rd_word_d;
  logic [TUPLE_BITS-1:0] st_data_q, st_data_d;
  logic                  st_last_q, st_last_d;

  logic                  b1_valid_q, b1_valid_d;
  logic [ROW_BITS-1:0]   b1_row_q, b1_row_d;

  logic                  p1_valid_q, p1_valid_d;
  logic [63:0]           p1_serial_q, p1_serial_d;
  logic [SLOTS-1:0]      p1_done_q, p1_done_d;

  logic                    out_valid_q, out_valid_d;
  logic [2*TUPLE_BITS-1:0] out_data_q, out_data_d;
  logic [63:0]             out_serial_q, out_serial_d;
  logic                    out_joined_q, out_joined_d;
  logic                    out_last_q, out_last_d;

  logic [7:0]            cur_count;
  logic                  row_full;
  logic [ROW_W-1:0]      new_word;
  logic                  wr_en;
  logic [ROW_BITS-1:0]   wr_addr;
  logic [ROW_W-1:0]      wr_data;
  logic [SLOTS-1:0]      match_mask;
  logic [SLOTS-1:0]      rem_mask;
  logic [SLOTS-1:0]      sel_mask;
  logic [TUPLE_BITS-1:0] sel_tuple;
  logic                  sel_found;
  logic                  final_beat;
  logic                  out_free;
  logic                  build_acc;
  logic                  probe_acc;
  logic [ROW_BITS-1:0]   build_row;
  logic [ROW_BITS-1:0]   probe_row;

  // Only the low hash bits select a row.
  logic unused_hash;
  assign unused_hash = ^{in_hash_BUILD[31:ROW_BITS], in_hash_PROBE[31:ROW_BITS]};

  assign build_row = in_hash_BUILD[ROW_BITS-1:0];
  assign probe_row = in_hash_PROBE[ROW_BITS-1:0];

  // Row update for the build tuple in stage 1, and the probe match engine.
  always_comb begin
    cur_count = rd_word_q[7:0];
    row_full  = (cur_count >= SLOTS_C);
    new_word  = rd_word_q;
    if (!row_full) begin
      for (int i = 0; i < SLOTS; i++) begin
        if (cur_count == 8'(i)) begin
          new_word[8 + i*TUPLE_BITS +: TUPLE_BITS] = st_data_q;
        end
      end
      new_word[7:0] = cur_count + 8'd1;
    end

    for (int i = 0; i < SLOTS; i++) begin
      match_mask[i] = (8'(i) < cur_count) &&
                      (rd_word_q[8 + i*TUPLE_BITS +: KEY_BITS] == st_data_q[KEY_BITS-1:0]);
    end
    rem_mask = match_mask & ~p1_done_q;

    // Lowest remaining match goes out next.
    sel_mask  = '0;
    sel_tuple = '0;
    sel_found = 1'b0;
    for (int i = 0; i < SLOTS; i++) begin
      if (!sel_found && rem_mask[i]) begin
        sel_found   = 1'b1;
        sel_mask[i] = 1'b1;
        sel_tuple   = rd_word_q[8 + i*TUPLE_BITS +: TUPLE_BITS];
      end
    end
    // Also true for an empty mask: the single unmatched beat ends the tuple.
    final_beat = ((rem_mask & ~sel_mask) == '0);
  end

  // Single write port: Init clears rows, Build commits the stage-1 row update.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = b1_row_q;
    wr_data = new_word;
    if (phase_q == PH_INIT) begin
      wr_en   = 1'b1;
      wr_addr = init_addr_q;
      wr_data = '0;
    end else if (b1_valid_q && !row_full) begin
      wr_en = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (resetn && wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    out_free       = !out_valid_q || out_ready;
    in_ready_BUILD = (phase_q == PH_BUILD) && !(b1_valid_q && st_last_q);
    // Accept only when the engine is idle or on its final beat, the output slot can
    // take a beat, and the last probe tuple has not been taken yet.
    in_ready_PROBE = (phase_q == PH_PROBE) && out_free &&
                     !(p1_valid_q && (st_last_q || !final_beat));
    build_acc      = in_valid_BUILD && in_ready_BUILD;
    probe_acc      = in_valid_PROBE && in_ready_PROBE;
  end

  always_comb begin
    phase_d      = phase_q;
    init_addr_d  = init_addr_q;
    ovf_d        = ovf_q;
    rd_word_d    = rd_word_q;
    st_data_d    = st_data_q;
    st_last_d    = st_last_q;
    b1_valid_d   = build_acc;
    b1_row_d     = b1_row_q;
    p1_valid_d   = p1_valid_q;
    p1_serial_d  = p1_serial_q;
    p1_done_d    = p1_done_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_serial_d = out_serial_q;
    out_joined_d = out_joined_q;
    out_last_d   = out_last_q;

    if (build_acc) begin
      // A same-row tuple one cycle ahead is still being written: take its new word.
      if (b1_valid_q && (b1_row_q == build_row)) begin
        rd_word_d = new_word;
      end else begin
        rd_word_d = mem_q[build_row];
      end
      st_data_d = in_data_BUILD;
      st_last_d = in_last_BUILD;
      b1_row_d  = build_row;
    end

    if (b1_valid_q && row_full && (ovf_q != 32'hFFFF_FFFF)) begin
      ovf_d = ovf_q + 32'd1;
    end

    if (out_free) begin
      out_valid_d = 1'b0;
      if (p1_valid_q) begin
        out_valid_d  = 1'b1;
        out_data_d   = {sel_tuple, st_data_q};
        out_serial_d = p1_serial_q;
        out_joined_d = sel_found;
        out_last_d   = st_last_q && final_beat;
        if (final_beat) begin
          p1_valid_d = 1'b0;
        end else begin
          p1_done_d = p1_done_q | sel_mask;
        end
      end
    end

    if (probe_acc) begin
      p1_valid_d  = 1'b1;
      p1_done_d   = '0;
      p1_serial_d = in_serialnum;
      rd_word_d   = mem_q[probe_row];
      st_data_d   = in_data_PROBE;
      st_last_d   = in_last_PROBE;
    end

    case (phase_q)
      PH_INIT: begin
        init_addr_d = init_addr_q + ROW_BITS'(1);
        if (&init_addr_q) begin
          phase_d = PH_BUILD;
          ovf_d   = '0;
        end
      end
      PH_BUILD: begin
        if (b1_valid_q && st_last_q) begin
          phase_d = PH_PROBE;
        end
      end
      PH_PROBE: begin
        if (out_free && p1_valid_q && final_beat && st_last_q) begin
          phase_d = PH_DRAIN;
        end
      end
      default: begin
        if (out_valid_q && out_ready) begin
          phase_d     = PH_INIT;
          init_addr_d = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      phase_q      <= PH_INIT;
      init_addr_q  <= '0;
      ovf_q        <= '0;
      rd_word_q    <= '0;
      st_data_q    <= '0;
      st_last_q    <= 1'b0;
      b1_valid_q   <= 1'b0;
      b1_row_q     <= '0;
      p1_valid_q   <= 1'b0;
      p1_serial_q  <= '0;
      p1_done_q    <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_serial_q <= '0;
      out_joined_q <= 1'b0;
      out_last_q   <= 1'b0;
    end else begin
      phase_q      <= phase_d;
      init_addr_q  <= init_addr_d;
      ovf_q        <= ovf_d;
      rd_word_q    <= rd_word_d;
      st_data_q    <= st_data_d;
      st_last_q    <= st_last_d;
      b1_valid_q   <= b1_valid_d;
      b1_row_q     <= b1_row_d;
      p1_valid_q   <= p1_valid_d;
      p1_serial_q  <= p1_serial_d;
      p1_done_q    <= p1_done_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_serial_q <= out_serial_d;
      out_joined_q <= out_joined_d;
      out_last_q   <= out_last_d;
    end
  end

  assign out_valid      = out_valid_q;
  assign out_data       = out_data_q;
  assign out_serialnum  = out_serial_q;
  assign out_was_joined = out_joined_q;
  assign out_last       = out_last_q;
  assign overflow_count = ovf_q;
  assign phase          = phase_q;

endmodule

// File: doc/hash_table_multi_match.md
# hash_table_multi_match

Parametrised per-partition hash table for the partitioned hash join. It clears itself, absorbs build tuples with a configurable number of slots per row, then probes with full ready/valid backpressure. It emits one output beat per matching build tuple, or one unmatched beat per probe tuple. It sits behind the partitioner and hash units and ahead of the result writer, and replaces the fixed 4-slot, first-match-only table.

## Interface
- TUPLE_BITS, 64, tuple width; the key is bits [KEY_BITS-1:0]
- KEY_BITS, 32, key width compared on probe (≤ TUPLE_BITS)
- ROW_BITS, 3, log2 of row count; NUM_ROWS = 2**ROW_BITS
- SLOTS, 4, tuples per row (1..8); row word = 8 + SLOTS*TUPLE_BITS bits (8-bit count + slots)
- clk  in  1  clock
- resetn  in  1  reset, synchronous, active-low
- in_valid_BUILD / in_ready_BUILD  in/out  1  build handshake
- in_data_BUILD  in  TUPLE_BITS  build tuple
- in_hash_BUILD  in  32  hash; row = hash[ROW_BITS-1:0]
- in_last_BUILD  in  1  marks final build tuple; valid only with in_valid_BUILD
- in_valid_PROBE / in_ready_PROBE  in/out  1  probe handshake
- in_data_PROBE  in  TUPLE_BITS  probe tuple
- in_hash_PROBE  in  32  probe hash
- in_last_PROBE  in  1  marks final probe tuple
- in_serialnum  in  64  probe tag, returned on every output beat of that tuple
- out_valid / out_ready  out/in  1  output handshake
- out_data  out  2*TUPLE_BITS  {build_tuple, probe_tuple}; build half is 0 when unmatched
- out_serialnum  out  64  tag of the probe tuple
- out_was_joined  out  1  1 = match beat, 0 = unmatched beat
- out_last  out  1  last beat of the last probe tuple
- overflow_count  out  32  build tuples dropped on full rows, saturating
- phase  out  2  0 Init, 1 Build, 2 Probe, 3 Drain

## Operation
- Init: writes all-zero rows to addresses 0..NUM_ROWS-1, one per cycle. Both in_ready are 0. After the last address: → Build, overflow_count cleared.
- Build: in_ready_BUILD = 1 and in_ready_PROBE = 0.
  - An accepted tuple reads its row, then writes the row back with the tuple in slot[count] and count+1.
  - If count == SLOTS, the write is skipped and overflow_count increments (saturates at 2^32-1).
  - Read-after-write hazard on the same row in consecutive cycles is resolved by forwarding the last written row word. Back-to-back same-row tuples must both land.
  - The accepted beat with in_last_BUILD: → Probe once its write has committed.
- Probe: tuples are accepted when the match engine is idle or finishing its last beat and the output register is free or being drained.
  - After the row read, all SLOTS compares (slot index < count AND key equal) run in parallel into a match mask.
  - Matches are emitted in ascending slot order, one beat per set mask bit, with the same serialnum on each beat.
  - Empty mask: a single beat with out_was_joined = 0.
  - in_ready_PROBE stays 0 while more than one beat remains for the current tuple.
- The accepted probe beat with in_last_PROBE: its final output beat carries out_last = 1 → Drain.
- Drain: when out_last is consumed (out_valid & out_ready) → Init, which starts the next partition.
- Outputs hold stable while out_valid & ~out_ready.

## Timing
- Reset values: out_valid 0, out_data 0, out_serialnum 0, out_was_joined 0, out_last 0, overflow_count 0, phase 0, in_ready_BUILD 0, in_ready_PROBE 0.
- Init lasts exactly NUM_ROWS cycles after resetn deasserts. in_ready_BUILD rises on cycle NUM_ROWS+1.
- Build: 1 tuple/cycle sustained. A tuple accepted in cycle t reads in t and writes at the end of t+1.
- Build→Probe: the last build tuple is accepted at t and its write commits at t+1. phase = 2 and in_ready_PROBE = 1 at t+2.
- Probe latency: a tuple accepted at t gives its first out_valid at t+2 with out_ready held high.
- Probe throughput: 1 beat/cycle. Single-beat tuples stream at 1 tuple/cycle.
- Probe stall: out_ready low freezes the entire probe pipeline, including the RAM read address.
- resetn low mid-phase: on the next edge all state returns to Init, in-flight tuples are discarded, and table contents are re-cleared.

## Test plan
- Reset, SLOTS=4, ROW_BITS=3: in_ready_BUILD is 0 for 8 cycles after resetn, then 1; phase goes 0→1.
- Build keys 5, 13, 21 all into row 1, back-to-back. Probe key 13 → one beat, out_data = {13-tuple, probe}, was_joined = 1.
- Build 3 tuples with key 7 into row 2 (duplicates). Probe key 7, serial 0x55 → 3 beats, slot order 0, 1, 2, all with serialnum 0x55. in_ready_PROBE is low for 2 cycles.
- Build 6 tuples into row 0 with SLOTS=4 → overflow_count = 2. Probe each key → the first 4 match and the last 2 return was_joined = 0.
- Probe with random out_ready at 30% and last on the final probe → no beats lost or duplicated; out_last appears exactly once on the final beat; phase then returns to 0 and 8 clear cycles follow.
- Assert resetn low during Probe with beats pending → out_valid = 0 next cycle, phase = 0, and a subsequent probe of old keys returns was_joined = 0.
